// File: rtl/blockram_arbiter.sv
// Two-requester arbiter in front of one port of a no-change, byte-write block RAM.
// Define BLOCKRAM_ARBITER_ROUND_ROBIN_EN for round-robin; otherwise requester 0 has fixed priority.
module blockram_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req0_valid,
   output logic                    req0_ready,
   input  logic [ADDR_WIDTH-1:0]   req0_addr,
   input  logic [DATA_WIDTH/8-1:0] req0_we,
   input  logic [DATA_WIDTH-1:0]   req0_wdata,
   output logic                    rsp0_valid,
   input  logic                    rsp0_ready,
   input  logic                    req1_valid,
   output logic                    req1_ready,
   input  logic [ADDR_WIDTH-1:0]   req1_addr,
   input  logic [DATA_WIDTH/8-1:0] req1_we,
   input  logic [DATA_WIDTH-1:0]   req1_wdata,
   output logic                    rsp1_valid,
   input  logic                    rsp1_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    ram_en,
   output logic [DATA_WIDTH/8-1:0] ram_we,
   output logic [ADDR_WIDTH-1:0]   ram_addr,
   output logic [DATA_WIDTH-1:0]   ram_di,
   input  logic [DATA_WIDTH-1:0]   ram_do
);

   logic pend, owner;
   logic consumed, can_acc, pick0;
   logic acc0, acc1, rd_acc;

   // A new access may only fire when the RAM output latch is free or being drained this cycle.
   assign consumed = pend & (owner ? rsp1_ready : rsp0_ready);
   assign can_acc  = rst_n & (~pend | consumed);

`ifdef BLOCKRAM_ARBITER_ROUND_ROBIN_EN
   logic prio;
   assign pick0 = ~prio;
`else
   assign pick0 = 1'b1;
`endif

   // Ready looks only at the other requester's valid, never at its own.
   assign req0_ready = can_acc & (~req1_valid | pick0);
   assign req1_ready = can_acc & (~req0_valid | ~pick0);

   assign acc0   = req0_valid & req0_ready;
   assign acc1   = req1_valid & req1_ready;
   assign rd_acc = (acc0 & ~|req0_we) | (acc1 & ~|req1_we);

   assign ram_en = acc0 | acc1;

   always_comb begin
      ram_addr = req0_addr;
      ram_di   = req0_wdata;
      ram_we   = '0;
      if (acc1) begin
         ram_addr = req1_addr;
         ram_di   = req1_wdata;
         ram_we   = req1_we;
      end else if (acc0) begin
         ram_we   = req0_we;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend  <= 1'b0;
         owner <= 1'b0;
      end else if (rd_acc) begin
         pend  <= 1'b1;
         owner <= acc1;
      end else if (consumed) begin
         pend  <= 1'b0;
      end
   end

`ifdef BLOCKRAM_ARBITER_ROUND_ROBIN_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    prio <= 1'b0;
      else if (acc0) prio <= 1'b1;
      else if (acc1) prio <= 1'b0;
   end
`endif

   assign rsp0_valid = pend & ~owner;
   assign rsp1_valid = pend & owner;
   assign rsp_rdata  = ram_do;

endmodule

// File: tb/tb_blockram_arbiter.sv
// Scoreboard bench for blockram_arbiter with a behavioural no-change byte-write RAM.
module tb_blockram_arbiter;
   localparam int DW = 32;
   localparam int AW = 10;
   localparam int BW = DW / 8;
`ifdef BLOCKRAM_ARBITER_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0_valid, req0_ready, rsp0_valid, rsp0_ready;
   logic [AW-1:0] req0_addr;
   logic [BW-1:0] req0_we;
   logic [DW-1:0] req0_wdata;
   logic          req1_valid, req1_ready, rsp1_valid, rsp1_ready;
   logic [AW-1:0] req1_addr;
   logic [BW-1:0] req1_we;
   logic [DW-1:0] req1_wdata;
   logic [DW-1:0] rsp_rdata, ram_di, ram_do;
   logic          ram_en;
   logic [BW-1:0] ram_we;
   logic [AW-1:0] ram_addr;

   int total = 0;
   int bad   = 0;
   bit m_prio = 1'b0;

   typedef struct {
      bit            who;
      logic [DW-1:0] data;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   blockram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
      .req0_we(req0_we), .req0_wdata(req0_wdata), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
      .req1_we(req1_we), .req1_wdata(req1_wdata), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_rdata(rsp_rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_di(ram_di), .ram_do(ram_do)
   );

   // Power-up contents are patt(a); both arrays hold the XOR delta from it.
   function automatic logic [DW-1:0] patt(input logic [AW-1:0] a);
      return {a[7:0] ^ 8'h5A, 8'hC3, a[7:0], ~a[7:0]};
   endfunction

   logic [DW-1:0] mem    [1024] = '{default: '0};
   logic [DW-1:0] shadow [1024] = '{default: '0};

   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we == '0) ram_do <= mem[ram_addr] ^ patt(ram_addr);
         else for (int b = 0; b < BW; b++)
            if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_di[8*b +: 8] ^ patt(ram_addr)[8*b +: 8];
      end
   end

   // Scoreboard: pop on consumed responses, push on accepted reads.
   logic          cons;
   exp_t          e;
   logic [DW-1:0] p;
   always @(negedge clk) begin
      if (rst_n) begin
         for (int n = 0; n < 2; n++) begin
            cons = (n == 0) ? (rsp0_valid & rsp0_ready) : (rsp1_valid & rsp1_ready);
            if (cons) begin
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL rsp%0d_unexpected: got data %h, no read outstanding", n, rsp_rdata);
               end else begin
                  e = exp_q.pop_front();
                  if (e.who != n[0] || rsp_rdata !== e.data) begin
                     bad++;
                     $display("FAIL rsp_data: got rsp%0d data %h, want rsp%0d data %h",
                              n, rsp_rdata, e.who, e.data);
                  end
               end
            end
         end
         if (req0_valid && req1_valid) begin
            total++;
            if (req0_ready && req1_ready) begin
               bad++;
               $display("FAIL double_grant: got both ready, want at most one");
            end
         end
         if (req0_valid && req0_ready) begin
            p = patt(req0_addr);
            if (req0_we == '0) exp_q.push_back('{1'b0, shadow[req0_addr] ^ p});
            else for (int b = 0; b < BW; b++)
               if (req0_we[b]) shadow[req0_addr][8*b +: 8] = req0_wdata[8*b +: 8] ^ p[8*b +: 8];
         end
         if (req1_valid && req1_ready) begin
            p = patt(req1_addr);
            if (req1_we == '0) exp_q.push_back('{1'b1, shadow[req1_addr] ^ p});
            else for (int b = 0; b < BW; b++)
               if (req1_we[b]) shadow[req1_addr][8*b +: 8] = req1_wdata[8*b +: 8] ^ p[8*b +: 8];
         end
      end
   end

   task automatic test_reset;
      #2;
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge clk);
      total++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_hs: got rdy %b%b rsp %b%b, want 00 00", req0_ready, req1_ready, rsp0_valid, rsp1_valid);
      end
      total++;
      if (ram_en !== 1'b0 || ram_we !== '0) begin
         bad++;
         $display("FAIL reset_ram: got en %b we %h, want 0 0", ram_en, ram_we);
      end
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0; rst_n = 1'b1;
   endtask

   task automatic test_both_read;
      req0_valid = 1'b1; req0_addr = 10'h010; req0_we = '0;
      req1_valid = 1'b1; req1_addr = 10'h020; req1_we = '0;
      @(negedge clk);
      total++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || ram_en !== 1'b1 || ram_addr !== 10'h010 || ram_we !== '0) begin
         bad++;
         $display("FAIL both_c0: got rdy %b%b en %b addr %h we %h, want 10 1 010 0", req0_ready, req1_ready, ram_en, ram_addr, ram_we);
      end
      @(posedge clk); #1;
      req0_valid = 1'b0; m_prio = 1'b1;
      @(negedge clk);
      total++;
      if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_rdata !== patt(10'h010)) begin
         bad++;
         $display("FAIL both_c1_rsp: got v %b%b data %h, want 10 %h", rsp0_valid, rsp1_valid, rsp_rdata, patt(10'h010));
      end
      total++;
      if (req1_ready !== 1'b1 || ram_en !== 1'b1 || ram_addr !== 10'h020) begin
         bad++;
         $display("FAIL both_c1_grant: got rdy1 %b en %b addr %h, want 1 1 020", req1_ready, ram_en, ram_addr);
      end
      @(posedge clk); #1;
      req1_valid = 1'b0; m_prio = 1'b0;
      @(negedge clk);
      total++;
      if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_rdata !== patt(10'h020)) begin
         bad++;
         $display("FAIL both_c2_rsp: got v %b%b data %h, want 01 %h", rsp0_valid, rsp1_valid, rsp_rdata, patt(10'h020));
      end
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
         bad++;
         $display("FAIL both_drain: got v %b%b, want 00", rsp0_valid, rsp1_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_stall;
      bit w;
      rsp0_ready = 1'b0;
      req0_valid = 1'b1; req0_addr = 10'h005; req0_we = '0;
      @(negedge clk);
      total++;
      if (req0_ready !== 1'b1) begin bad++; $display("FAIL stall_acc: got rdy0 %b, want 1", req0_ready); end
      @(posedge clk); #1;
      m_prio = 1'b1;
      req0_addr = 10'h007; req1_valid = 1'b1; req1_addr = 10'h008; req1_we = '0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         total++;
         if (rsp0_valid !== 1'b1 || rsp_rdata !== patt(10'h005)) begin
            bad++;
            $display("FAIL stall_hold%0d: got v %b data %h, want 1 %h", k, rsp0_valid, rsp_rdata, patt(10'h005));
         end
         total++;
         if (ram_en !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_block%0d: got en %b rdy %b%b, want 0 00", k, ram_en, req0_ready, req1_ready);
         end
         @(posedge clk); #1;
      end
      rsp0_ready = 1'b1;
      w = RR ? m_prio : 1'b0;
      @(negedge clk);
      total++;
      if (req0_ready !== !w || req1_ready !== w || ram_en !== 1'b1) begin
         bad++;
         $display("FAIL stall_resume: got rdy %b%b en %b, want winner %0d en 1", req0_ready, req1_ready, ram_en, w);
      end
      @(posedge clk); #1;
      m_prio = ~w;
      if (w) req1_valid = 1'b0; else req0_valid = 1'b0;
      @(negedge clk);
      total++;
      if ((w ? rsp1_valid : rsp0_valid) !== 1'b1 || (w ? req0_ready : req1_ready) !== 1'b1) begin
         bad++;
         $display("FAIL stall_second: got rsp %b%b rdy %b%b, want rsp for %0d and other ready", rsp0_valid, rsp1_valid, req0_ready, req1_ready, w);
      end
      @(posedge clk); #1;
      m_prio = w;
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic test_write;
      req1_valid = 1'b1; req1_addr = 10'h003; req1_we = 4'hF; req1_wdata = 32'hA5A5A5A5;
      @(negedge clk);
      total++;
      if (req1_ready !== 1'b1 || ram_en !== 1'b1 || ram_we !== 4'hF || ram_di !== 32'hA5A5A5A5 || ram_addr !== 10'h003) begin
         bad++;
         $display("FAIL wr_full: got rdy %b en %b we %h di %h addr %h", req1_ready, ram_en, ram_we, ram_di, ram_addr);
      end
      @(posedge clk); #1;
      m_prio = 1'b0;
      req1_we = 4'h2; req1_wdata = 32'h00003C00;
      @(negedge clk);
      total++;
      if (rsp1_valid !== 1'b0 || ram_we !== 4'h2 || ram_di !== 32'h00003C00) begin
         bad++;
         $display("FAIL wr_byte: got rsp %b we %h di %h, want 0 2 00003c00", rsp1_valid, ram_we, ram_di);
      end
      @(posedge clk); #1;
      req1_we = '0;
      @(negedge clk);
      total++;
      if (rsp1_valid !== 1'b0 || ram_en !== 1'b1 || ram_we !== '0) begin
         bad++;
         $display("FAIL wr_rd_acc: got rsp %b en %b we %h, want 0 1 0", rsp1_valid, ram_en, ram_we);
      end
      @(posedge clk); #1;
      req1_valid = 1'b0;
      @(negedge clk);
      total++;
      if (rsp1_valid !== 1'b1 || rsp_rdata !== 32'hA5A53CA5) begin
         bad++;
         $display("FAIL wr_readback: got v %b data %h, want 1 a5a53ca5", rsp1_valid, rsp_rdata);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_conflict;
      int i0 = 0;
      int i1 = 0;
      bit w;
      req0_valid = 1'b1; req0_addr = 10'h100; req0_we = '0;
      req1_valid = 1'b1; req1_addr = 10'h200; req1_we = '0;
      for (int k = 0; k < 4; k++) begin
         w = RR ? m_prio : 1'b0;
         @(negedge clk);
         total++;
         if (req0_ready !== !w || req1_ready !== w || ram_addr !== (w ? req1_addr : req0_addr)) begin
            bad++;
            $display("FAIL conflict%0d: got rdy %b%b addr %h, want winner %0d", k, req0_ready, req1_ready, ram_addr, w);
         end
         @(posedge clk); #1;
         if (w) begin i1++; req1_addr = 10'h200 + 10'(i1); end
         else   begin i0++; req0_addr = 10'h100 + 10'(i0); end
         m_prio = ~w;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      total++;
      if ((rsp0_valid ^ rsp1_valid) !== 1'b1) begin
         bad++;
         $display("FAIL conflict_last: got v %b%b, want exactly one", rsp0_valid, rsp1_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      req0_valid = 1'b1; req0_addr = 10'h040; req0_we = '0;
      @(negedge clk);
      total++;
      if (req0_ready !== 1'b1) begin bad++; $display("FAIL rmid_acc: got rdy0 %b, want 1", req0_ready); end
      @(posedge clk); #1;
      req0_valid = 1'b0; rst_n = 1'b0;
      exp_q.delete(); m_prio = 1'b0;
      @(negedge clk);
      total++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
         bad++;
         $display("FAIL rmid_in_reset: got v %b%b, want 00", rsp0_valid, rsp1_valid);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
         bad++;
         $display("FAIL rmid_released: got v %b%b, want 00", rsp0_valid, rsp1_valid);
      end
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_addr = 10'h042;
      req1_valid = 1'b1; req1_addr = 10'h041; req1_we = '0;
      @(negedge clk);
      total++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         bad++;
         $display("FAIL rmid_first_grant: got rdy %b%b, want 10", req0_ready, req1_ready);
      end
      @(posedge clk); #1;
      req0_valid = 1'b0; m_prio = 1'b1;
      @(negedge clk);
      total++;
      if (rsp0_valid !== 1'b1 || rsp_rdata !== patt(10'h042)) begin
         bad++;
         $display("FAIL rmid_rsp: got v %b data %h, want 1 %h", rsp0_valid, rsp_rdata, patt(10'h042));
      end
      @(posedge clk); #1;
      req1_valid = 1'b0; m_prio = 1'b0;
      @(negedge clk);
      total++;
      if (rsp1_valid !== 1'b1 || rsp_rdata !== patt(10'h041)) begin
         bad++;
         $display("FAIL rmid_rsp1: got v %b data %h, want 1 %h", rsp1_valid, rsp_rdata, patt(10'h041));
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0;
      req0_valid = 1'b0; req0_addr = '0; req0_we = '0; req0_wdata = '0; rsp0_ready = 1'b1;
      req1_valid = 1'b0; req1_addr = '0; req1_we = '0; req1_wdata = '0; rsp1_ready = 1'b1;
      test_reset;
      test_both_read;
      test_stall;
      test_write;
      test_conflict;
      test_reset_mid;
      @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL sb_leftover: got %0d outstanding reads, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
